shared_reg_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one 10-bit configuration register

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_picker.sv | 34 +++
 rtl/shared_reg_arbiter.sv | 125 ++++++++++++
 tb/tb_shared_reg_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the shared configuration register arbiter.
package arb_pkg;

    localparam int DATA_W      = 10;
    localparam int HOLD_CYCLES = 2;

    localparam logic [DATA_W-1:0] INIT_VALUE = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

    // Width of the hold counter: max(1, clog2(n)), so HOLD_CYCLES of 0 or 1 still
    // gets a legal one-bit vector.
    function automatic int hold_cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first asserted request searching
// upward from the position just after the previous winner, wrapping at N_REQ.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_index,
    output logic             o_valid
);

    logic [IDX_W-1:0] cand;

    assign o_valid = |i_req;

    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
        o_onehot = '0;
        o_index  = '0;
        cand     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(i_last) + k) % N_REQ);
            if (i_req[cand]) begin
                o_onehot       = '0;
                o_onehot[cand] = 1'b1;
                o_index        = cand;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin sequencer that lets N_REQ clients take turns loading one shared
// register, followed by a fixed hold window during which the value is stable.
module shared_reg_arbiter #(
    parameter int                N_REQ       = 4,
    parameter int                DATA_W      = arb_pkg::DATA_W,
    parameter int                HOLD_CYCLES = arb_pkg::HOLD_CYCLES,
    parameter logic [DATA_W-1:0] INIT_VALUE  = arb_pkg::INIT_VALUE
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [DATA_W-1:0]       o_value,
    output logic                    o_upd,
    output logic                    o_busy
);

    import arb_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = hold_cnt_width(HOLD_CYCLES);

    // Counter preload on entering HOLD; the zero-hold case never uses it.
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

    arb_state_t        state_q,    state_d;
    logic [N_REQ-1:0]  gnt_q,      gnt_d;
    logic [DATA_W-1:0] value_q,    value_d;
    logic              upd_q,      upd_d;
    logic [IDX_W-1:0]  last_q,     last_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_index;
    logic              pick_valid;

    logic [DATA_W-1:0] data_arr [N_REQ];

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign data_arr[k] = i_data[k*DATA_W +: DATA_W];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req    (i_req),
        .i_last   (last_q),
        .o_onehot (pick_onehot),
        .o_index  (pick_index),
        .o_valid  (pick_valid)
    );

    // Next-state, grant, load and hold-count logic.
    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        value_d    = value_q;
        upd_d      = 1'b0;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_onehot;
                    last_d  = pick_index;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Winner still requesting while it sees its grant: load its slice.
                if (i_req[last_q]) begin
                    value_d = data_arr[last_q];
                    upd_d   = 1'b1;
                end
                if (HOLD_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; an in-flight load is discarded.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
        if (i_rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            value_q    <= INIT_VALUE;
            upd_q      <= 1'b0;
            last_q     <= LAST_RESET;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            value_q    <= value_d;
            upd_q      <= upd_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_value = value_q;
    assign o_upd   = upd_q;
    assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: a default instance (hold of 2) and a
// zero-hold instance, with grant/value scoreboards checked every cycle.
module tb_shared_reg_arbiter;

    import arb_pkg::DATA_W;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [N-1:0]        req,   req0;
    logic [N*DATA_W-1:0] data,  data0;
    logic [N-1:0]        gnt,   gnt0;
    logic [DATA_W-1:0]   value, value0;
    logic                upd,   upd0;
    logic                busy,  busy0;

    shared_reg_arbiter #(.N_REQ(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req),
        .i_data  (data),
        .o_gnt   (gnt),
        .o_value (value),
        .o_upd   (upd),
        .o_busy  (busy)
    );

    shared_reg_arbiter #(.N_REQ(N), .HOLD_CYCLES(0)) dut0 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_req   (req0),
        .i_data  (data0),
        .o_gnt   (gnt0),
        .o_value (value0),
        .o_upd   (upd0),
        .o_busy  (busy0)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboards: expected grants and loaded values, in order, per instance.
    logic [N-1:0]      sb_gnt  [$];
    logic [DATA_W-1:0] sb_val  [$];
    logic [N-1:0]      sb0_gnt [$];
    logic [DATA_W-1:0] sb0_val [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare every grant and every update pulse against the scoreboards.
    task automatic monitor();
        check("onehot", 32'($onehot0(gnt)), 32'd1);
        check("onehot0", 32'($onehot0(gnt0)), 32'd1);
        if (gnt !== '0) begin
            if (sb_gnt.size() > 0) check("sb_gnt", 32'(gnt), 32'(sb_gnt.pop_front()));
            else                   check("sb_gnt_unexpected", 32'(gnt), 32'd0);
        end
        if (upd === 1'b1) begin
            if (sb_val.size() > 0) check("sb_val", 32'(value), 32'(sb_val.pop_front()));
            else                   check("sb_upd_unexpected", 32'(upd), 32'd0);
        end
        if (gnt0 !== '0) begin
            if (sb0_gnt.size() > 0) check("sb0_gnt", 32'(gnt0), 32'(sb0_gnt.pop_front()));
            else                    check("sb0_gnt_unexpected", 32'(gnt0), 32'd0);
        end
        if (upd0 === 1'b1) begin
            if (sb0_val.size() > 0) check("sb0_val", 32'(value0), 32'(sb0_val.pop_front()));
            else                    check("sb0_upd_unexpected", 32'(upd0), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        monitor();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_gnt;

        // Reset and idle.
        rst   = 1'b1;
        req   = '0;
        data  = '0;
        req0  = '0;
        data0 = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();
        check("rst_gnt",   32'(gnt),   32'd0);
        check("rst_value", 32'(value), 32'd0);
        check("rst_upd",   32'(upd),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);

        // Single requester 2: grant at t+1, load at t+2, busy for three cycles.
        data[2*DATA_W +: DATA_W] = 10'h155;
        req = 4'b0100;
        sb_gnt.push_back(4'b0100);
        sb_val.push_back(10'h155);
        step();
        check("t2_gnt",   32'(gnt),  32'h4);
        check("t2_busy1", 32'(busy), 32'd1);
        check("t2_upd_early", 32'(upd), 32'd0);
        step();
        check("t2_value", 32'(value), 32'h155);
        check("t2_upd",   32'(upd),   32'd1);
        check("t2_busy2", 32'(busy),  32'd1);
        check("t2_gnt_off", 32'(gnt), 32'd0);
        req = '0;
        step();
        check("t2_busy3", 32'(busy), 32'd1);
        check("t2_upd_once", 32'(upd), 32'd0);
        step();
        check("t2_idle", 32'(busy), 32'd0);

        // All four requesting from reset: rotation 0,1,2,3,0 every four cycles.
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int k = 0; k < N; k++) data[k*DATA_W +: DATA_W] = DATA_W'(k + 1);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            sb_gnt.push_back(N'(1) << (i % N));
            sb_val.push_back(DATA_W'((i % N) + 1));
        end
        for (int i = 0; i < 5; i++) begin
            exp_gnt = N'(1) << (i % N);
            step();
            check("t3_gnt", 32'(gnt), 32'(exp_gnt));
            step();
            check("t3_value", 32'(value), 32'((i % N) + 1));
            if (i == 4) req = '0;
            step();
            step();
        end
        check("t3_idle", 32'(busy), 32'd0);

        // Requester 3 drops its request in the grant cycle: no load.
        data[3*DATA_W +: DATA_W] = 10'h2AA;
        req = 4'b1000;
        sb_gnt.push_back(4'b1000);
        step();
        check("t4_gnt", 32'(gnt), 32'h8);
        req = '0;
        step();
        check("t4_no_upd", 32'(upd),   32'd0);
        check("t4_hold_v", 32'(value), 32'd1);
        step();
        step();
        check("t4_idle", 32'(busy), 32'd0);
        data[0 +: DATA_W] = 10'h0AB;
        req = 4'b1001;
        sb_gnt.push_back(4'b0001);
        sb_val.push_back(10'h0AB);
        step();
        check("t4_next_gnt", 32'(gnt), 32'h1);
        step();
        check("t4_next_val", 32'(value), 32'h0AB);
        req = '0;
        step();
        step();

        // Reset in the hold window after loading 3FF.
        data[2*DATA_W +: DATA_W] = 10'h3FF;
        req = 4'b0100;
        sb_gnt.push_back(4'b0100);
        sb_val.push_back(10'h3FF);
        step();
        check("t5_gnt", 32'(gnt), 32'h4);
        step();
        check("t5_value", 32'(value), 32'h3FF);
        req = '0;
        rst = 1'b1;
        step();
        check("t5_rst_value", 32'(value), 32'd0);
        check("t5_rst_gnt",   32'(gnt),   32'd0);
        check("t5_rst_busy",  32'(busy),  32'd0);
        check("t5_rst_upd",   32'(upd),   32'd0);
        rst = 1'b0;
        req = 4'b1001;
        sb_gnt.push_back(4'b0001);
        sb_val.push_back(10'h0AB);
        step();
        check("t5_first_gnt", 32'(gnt), 32'h1);
        step();
        check("t5_first_val", 32'(value), 32'h0AB);
        req = '0;
        step();
        step();

        // Zero-hold instance: requesters 0 and 1 alternate every two cycles.
        data0[0 +: DATA_W]      = 10'd1;
        data0[DATA_W +: DATA_W] = 10'd2;
        req0 = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            sb0_gnt.push_back(N'(1) << (i % 2));
            sb0_val.push_back(DATA_W'((i % 2) + 1));
        end
        for (int i = 0; i < 4; i++) begin
            exp_gnt = N'(1) << (i % 2);
            step();
            check("t6_gnt",  32'(gnt0),  32'(exp_gnt));
            check("t6_busy", 32'(busy0), 32'd1);
            step();
            check("t6_value",   32'(value0), 32'((i % 2) + 1));
            check("t6_upd",     32'(upd0),   32'd1);
            check("t6_idle",    32'(busy0),  32'd0);
            check("t6_gnt_off", 32'(gnt0),   32'd0);
            if (i == 3) req0 = '0;
        end
        step();
        check("t6_end_busy", 32'(busy0), 32'd0);

        // Every expected grant and load must have been observed.
        check("sb_gnt_left",  32'(sb_gnt.size()),  32'd0);
        check("sb_val_left",  32'(sb_val.size()),  32'd0);
        check("sb0_gnt_left", 32'(sb0_gnt.size()), 32'd0);
        check("sb0_val_left", 32'(sb0_val.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
